// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, receiver FSM states and baud divisor helper.
package uart_pkg;

  localparam int WIDTH = 8;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/rx_pipe_if.sv
// Consumer-side bus of rx_pipe: FIFO head, status, sticky flags and receiver state.
interface rx_pipe_if;
  import uart_pkg::*;

  // pop_front is a one-cycle strobe honoured only while empty is low; data_out is
  // the FIFO head and is meaningful only while empty is low.
  logic             pop_front;
  logic             err_clear;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             frame_error;
  rx_state_t        dbg_state;

  modport master (
    output pop_front, err_clear,
    input  data_out, empty, full, overflow, frame_error, dbg_state
  );

  modport slave (
    input  pop_front, err_clear,
    output data_out, empty, full, overflow, frame_error, dbg_state
  );

endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, framing FSM, bit timer and shift register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 9_600
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_frame_err,
  output rx_state_t        dbg_state
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] CNT_FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);

  logic             sync1_q, sync2_q;
  rx_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             rxs;
  logic             expire;

  assign rxs    = sync2_q;
  assign expire = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = expire ? cnt_q : cnt_q - CW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      // The line must read high for a full bit time; the synchroniser's reset
      // value alone must not release a receiver that came out of reset mid-frame.
      WAIT_IDLE: begin
        if (!rxs)        cnt_d   = CNT_FULL;
        else if (expire) state_d = IDLE;
      end
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = CNT_HALF;
        end
      end
      START: begin
        if (expire) begin
          if (!rxs) begin
            state_d   = DATA;
            cnt_d     = CNT_FULL;
            bit_idx_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (expire) begin
          shift_d   = {rxs, shift_q[WIDTH-1:1]};
          cnt_d     = CNT_FULL;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (expire) begin
          if (rxs) begin
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
            cnt_d   = CNT_FULL;
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= WAIT_IDLE;
      cnt_q     <= CNT_FULL;
      bit_idx_q <= 3'd0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx_data      = shift_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign dbg_state    = state_q;

endmodule

// File: rtl/rx_pipe.sv
// UART receive path: uart_rx feeding a first-word-fall-through byte FIFO with
// sticky overflow and framing-error flags.
module rx_pipe
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 9_600,
  parameter int DEPTH    = 16
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rx,
  rx_pipe_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_frame_err;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .dbg_state    (bus.dbg_state)
  );

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             overflow_q, overflow_d;
  logic             frame_error_q, frame_error_d;
  logic             do_push, do_pop, drop;

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  always_comb begin
    do_pop        = bus.pop_front && !empty_q;
    do_push       = rx_valid && (!full_q || do_pop);
    drop          = rx_valid && full_q && !do_pop;
    wr_ptr_d      = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d      = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d       = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    empty_d       = (count_d == '0);
    full_d        = (count_d == FULL_CNT);
    overflow_d    = drop | (overflow_q & ~bus.err_clear);
    frame_error_d = rx_frame_err | (frame_error_q & ~bus.err_clear);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      overflow_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      empty_q       <= empty_d;
      full_q        <= full_d;
      overflow_q    <= overflow_d;
      frame_error_q <= frame_error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= rx_data;
  end

  // Storage is not reset, so the head is forced to zero while nothing is held.
  assign bus.data_out    = empty_q ? '0 : mem_q[rd_ptr_q];
  assign bus.empty       = empty_q;
  assign bus.full        = full_q;
  assign bus.overflow    = overflow_q;
  assign bus.frame_error = frame_error_q;

endmodule
